// File: rtl/fg_pkg.sv
// Shared amplitude codes and controller state encoding for the function generator.
// The attenuator and amp_step_controller both decode amp_sel with these values.
package fg_pkg;

  typedef logic [1:0] amp_t;

  localparam amp_t AMP_FULL    = 2'b00;
  localparam amp_t AMP_HALF    = 2'b01;
  localparam amp_t AMP_QUARTER = 2'b10;
  localparam amp_t AMP_EIGHTH  = 2'b11;

  typedef enum logic [1:0] {
    ST_MANUAL   = 2'd0,
    ST_SWEEP_DN = 2'd1,
    ST_SWEEP_UP = 2'd2
  } state_e;

  // One step quieter (larger code), pinned at AMP_EIGHTH.
  function automatic amp_t amp_quieter(input amp_t a);
    return (a == AMP_EIGHTH) ? a : amp_t'(a + 2'd1);
  endfunction

  // One step louder (smaller code), pinned at AMP_FULL.
  function automatic amp_t amp_louder(input amp_t a);
    return (a == AMP_FULL) ? a : amp_t'(a - 2'd1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with optional registered rising-edge pulse.
// The pulse is registered, so an input high at edge E0 is seen by consumers at E3.
module sync_edge #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign level_o = s2_q;

  generate
    if (EDGE_EN) begin : g_edge
      logic s3_q, rise_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          s3_q   <= 1'b0;
          rise_q <= 1'b0;
        end else begin
          s3_q   <= s2_q;
          rise_q <= s2_q & ~s3_q;
        end
      end

      assign rise_o = rise_q;
    end else begin : g_level_only
      assign rise_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/amp_step_controller.sv
// Amplitude attenuator sequencer: manual saturating steps or automatic ping-pong sweep,
// with every amp_sel change deferred to a waveform-period boundary (wave_wrap).
module amp_step_controller #(
  parameter int unsigned SWEEP_PERIODS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic       sweep_en,
  input  logic       wave_wrap,
  output logic [1:0] amp_sel,
  output logic       pend,
  output logic       at_max,
  output logic       at_min
);

  import fg_pkg::*;

  localparam logic [7:0] LAST_WRAP = 8'(SWEEP_PERIODS - 1);

  logic inc_rise, dec_rise, sweep_s;
  logic inc_lvl_unused, dec_lvl_unused, sweep_rise_unused;

  sync_edge #(.EDGE_EN(1'b1)) u_inc (
    .clk_i(clk), .rst_i(rst), .d_i(inc_btn), .level_o(inc_lvl_unused), .rise_o(inc_rise)
  );

  sync_edge #(.EDGE_EN(1'b1)) u_dec (
    .clk_i(clk), .rst_i(rst), .d_i(dec_btn), .level_o(dec_lvl_unused), .rise_o(dec_rise)
  );

  sync_edge #(.EDGE_EN(1'b0)) u_sweep (
    .clk_i(clk), .rst_i(rst), .d_i(sweep_en), .level_o(sweep_s), .rise_o(sweep_rise_unused)
  );

  state_e     state_q, state_d;
  amp_t       sel_q, sel_d;
  amp_t       tgt_q, tgt_d;
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_MANUAL;
      sel_q   <= AMP_FULL;
      tgt_q   <= AMP_FULL;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  // A wrap in the same cycle as a mode change is resolved under the old state's rules
  // first; the mode-change overrides are then layered on top of that result.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_MANUAL: begin
        if (wave_wrap) sel_d = tgt_q;
        if (inc_rise && !dec_rise)      tgt_d = amp_louder(tgt_q);
        else if (dec_rise && !inc_rise) tgt_d = amp_quieter(tgt_q);
        if (sweep_s) begin
          state_d = (sel_d == AMP_EIGHTH) ? ST_SWEEP_UP : ST_SWEEP_DN;
          cnt_d   = 8'd0;
          tgt_d   = sel_d;
        end
      end
      ST_SWEEP_DN, ST_SWEEP_UP: begin
        if (wave_wrap) begin
          if (cnt_q == LAST_WRAP) begin
            cnt_d = 8'd0;
            if (state_q == ST_SWEEP_DN) begin
              sel_d = amp_quieter(sel_q);
              if (sel_d == AMP_EIGHTH) state_d = ST_SWEEP_UP;
            end else begin
              sel_d = amp_louder(sel_q);
              if (sel_d == AMP_FULL) state_d = ST_SWEEP_DN;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        tgt_d = sel_d;
        if (!sweep_s) begin
          state_d = ST_MANUAL;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = ST_MANUAL;
    endcase
  end

  assign amp_sel = sel_q;
  assign pend    = (tgt_q != sel_q);
  assign at_max  = (sel_q == AMP_FULL);
  assign at_min  = (sel_q == AMP_EIGHTH);

endmodule
